// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory access controller.
//   state_e   : controller FSM states (IDLE, REQ, WAIT_R, DONE)
//   F3_*      : funct3 encodings for access size and sign
//   access_t  : fields latched when an access is accepted
//   is_misaligned() : natural-alignment test used by the optional trap
//                     (DMEM_MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  funct3;
  } access_t;

  // Halfwords must sit on an even byte, words on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Request/grant/read-valid memory bus between the access controller and the
// data memory.
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : controller -> memory
//   mem_gnt/mem_rvalid/mem_rdata             : memory -> controller
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane logic for sub-word accesses.
//   addr_lo    in  2   byte offset within the word
//   funct3     in  3   access size/sign
//   store_data in  32  register value to be stored
//   read_word  in  32  word returned by memory
//   byte_en    out 4   byte enables
//   store_word out 32  store data replicated onto every lane
//   load_word  out 32  selected lane, sign/zero extended
// Offset bits that do not matter for the access size are simply ignored, so a
// misaligned halfword/word behaves as if those bits were zero.
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = read_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    byte_en    = 4'b1111;
    store_word = store_data;
    load_word  = read_word;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_word  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_word  = {24'h0, byte_sel};
      end
      F3_H: begin
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        store_word = {2{store_data[15:0]}};
        load_word  = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        store_word = {2{store_data[15:0]}};
        load_word  = {16'h0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data memory access controller. Accepts one load/store per
// Dcache_en pulse, runs it over a req/gnt/rvalid bus and stalls the pipeline
// until it completes.
//   clk, rst         : clock, asynchronous active-low reset
//   Dcache_en        : access request (first MEM cycle only)
//   Dcache_write     : 1 = store, 0 = load
//   D_address        : byte address
//   Read_data_2_MEM  : store data
//   funct3_MEM       : size/sign
//   Istall           : fetch-side stall (controller state is unaffected)
//   mem              : memory bus, master modport
//   Dstall           : pipeline hold while an access is outstanding
//   load_data        : extended load result, held until the next load
//   mem_misalign     : one-cycle misaligned-access pulse
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses instead of issuing them with the low address bits dropped.
// -----------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Dcache_en,
  input  logic                      Dcache_write,
  input  logic [31:0]               D_address,
  input  logic [31:0]               Read_data_2_MEM,
  input  logic [2:0]                funct3_MEM,
  input  logic                      Istall,
  dmem_access_ctrl_if.master        mem,
  output logic                      Dstall,
  output logic [31:0]               load_data,
  output logic                      mem_misalign
);

  state_e      state_reg;
  access_t     acc_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic        mem_req_reg;
  logic [31:0] load_data_reg;
  logic        misalign_reg;

  logic        accept;
  logic        misalign_in;
  logic [1:0]  sel_addr_lo;
  logic [2:0]  sel_funct3;
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] load_word;
  logic        unused_inputs;

  // Istall only freezes the pipeline; every controller output already holds
  // its value across such stalls.
  assign unused_inputs = Istall;

  assign accept = (state_reg == IDLE) && Dcache_en;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_in = is_misaligned(funct3_MEM, D_address[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  // One lane aligner serves both ends of an access: in IDLE it sees the
  // incoming request (byte enables / store data get registered), afterwards
  // it sees the latched fields (load extraction on the returned word).
  assign sel_addr_lo = (state_reg == IDLE) ? D_address[1:0] : acc_reg.addr[1:0];
  assign sel_funct3  = (state_reg == IDLE) ? funct3_MEM     : acc_reg.funct3;

  dmem_lane_align u_lane_align (
    .addr_lo    (sel_addr_lo),
    .funct3     (sel_funct3),
    .store_data (Read_data_2_MEM),
    .read_word  (mem.mem_rdata),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_word  (load_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      mem_be_reg    <= '0;
      mem_wdata_reg <= '0;
      mem_req_reg   <= 1'b0;
      load_data_reg <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg.addr   <= D_address;
            acc_reg.write  <= Dcache_write;
            acc_reg.funct3 <= funct3_MEM;
            if (misalign_in) begin
              // Trapped access: never reaches the bus.
              misalign_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              mem_be_reg    <= byte_en;
              mem_wdata_reg <= store_word;
              mem_req_reg   <= 1'b1;
              state_reg     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem_req_reg <= 1'b0;
            if (acc_reg.write) begin
              state_reg <= DONE;
            end else if (mem.mem_rvalid) begin
              load_data_reg <= load_word;
              state_reg     <= DONE;
            end else begin
              state_reg <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem.mem_rvalid) begin
            load_data_reg <= load_word;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          misalign_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall rises combinationally on the accepting IDLE cycle so the pipeline
  // never advances past an access it has just handed over.
  assign Dstall = accept || (state_reg == REQ) || (state_reg == WAIT_R);

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = acc_reg.write;
  assign mem.mem_addr  = {acc_reg.addr[31:2], 2'b00};
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_wdata = mem_wdata_reg;

  assign load_data    = load_data_reg;
  assign mem_misalign = misalign_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Directed bench for dmem_access_ctrl: the bench plays the memory on the
// interface and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        Dcache_en;
  logic        Dcache_write;
  logic [31:0] D_address;
  logic [31:0] Read_data_2_MEM;
  logic [2:0]  funct3_MEM;
  logic        Istall;
  logic        Dstall;
  logic [31:0] load_data;
  logic        mem_misalign;

  int err_cnt;
  int chk_cnt;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .Dcache_en       (Dcache_en),
    .Dcache_write    (Dcache_write),
    .D_address       (D_address),
    .Read_data_2_MEM (Read_data_2_MEM),
    .funct3_MEM      (funct3_MEM),
    .Istall          (Istall),
    .mem             (bus.master),
    .Dstall          (Dstall),
    .load_data       (load_data),
    .mem_misalign    (mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one access. Returns inside the DONE cycle (negedge + 1).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] f3, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, output int stalls,
                        output logic [3:0] be_s, output logic [31:0] addr_s,
                        output logic [31:0] wdata_s);
    stalls          = 0;
    Dcache_en       = 1'b1;
    Dcache_write    = we;
    D_address       = addr;
    Read_data_2_MEM = data;
    funct3_MEM      = f3;
    #1;
    if (Dstall) stalls++;
    tick();
    Dcache_en       = 1'b0;
    D_address       = 32'h0;
    Read_data_2_MEM = 32'h0;
    funct3_MEM      = 3'b000;
    for (int i = 0; i <= gnt_dly; i++) begin
      bus.mem_gnt = (i == gnt_dly);
      if (!we && rv_dly == 0 && i == gnt_dly) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
      end
      #1;
      if (Dstall) stalls++;
      check("req_high", bus.mem_req, 1);
      be_s    = bus.mem_be;
      addr_s  = bus.mem_addr;
      wdata_s = bus.mem_wdata;
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    if (!we) begin
      for (int j = 1; j <= rv_dly; j++) begin
        bus.mem_rvalid = (j == rv_dly);
        bus.mem_rdata  = (j == rv_dly) ? rdata : 32'h0;
        #1;
        if (Dstall) stalls++;
        check("wait_no_req", bus.mem_req, 0);
        tick();
      end
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    #1;
    check("done_stall", Dstall, 0);
    check("done_req", bus.mem_req, 0);
    $display("txn %s addr=%h f3=%b be=%b wdata=%h load_data=%h stalls=%0d",
             we ? "store" : "load", addr, f3, be_s, wdata_s, load_data, stalls);
  endtask

  int          st;
  logic [3:0]  be_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;

  initial begin
    err_cnt         = 0;
    chk_cnt         = 0;
    rst             = 1'b0;
    Dcache_en       = 1'b0;
    Dcache_write    = 1'b0;
    D_address       = 32'h0;
    Read_data_2_MEM = 32'h0;
    funct3_MEM      = 3'b000;
    Istall          = 1'b0;
    bus.mem_gnt     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_be", bus.mem_be, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_load", load_data, 0);
    check("rst_misalign", mem_misalign, 0);
    check("rst_stall", Dstall, 0);
    rst = 1'b1;
    tick();

    // LB 0x203, rvalid 3 cycles after gnt
    access(1'b0, 32'h0000_0203, 32'h0, F3_B, 0, 3, 32'h80FF_FFFF, st, be_s, addr_s, wdata_s);
    check("lb_be", be_s, 4'b1000);
    check("lb_addr", addr_s, 32'h0000_0200);
    check("lb_load", load_data, 32'hFFFF_FF80);
    check("lb_stalls", st, 5);
    tick();

    // SW 0x100, gnt after 2 cycles
    access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, F3_W, 2, 0, 32'h0, st, be_s, addr_s, wdata_s);
    check("sw_be", be_s, 4'b1111);
    check("sw_wdata", wdata_s, 32'hDEAD_BEEF);
    check("sw_addr", addr_s, 32'h0000_0100);
    check("sw_stalls", st, 4);
    check("sw_keeps_load", load_data, 32'hFFFF_FF80);
    tick();

    // SB replicates the low byte
    access(1'b1, 32'h0000_0181, 32'h1234_56A5, F3_B, 0, 0, 32'h0, st, be_s, addr_s, wdata_s);
    check("sb_be", be_s, 4'b0010);
    check("sb_wdata", wdata_s, 32'hA5A5_A5A5);
    tick();

    // LHU 0x302, gnt and rvalid together: WAIT_R skipped
    access(1'b0, 32'h0000_0302, 32'h0, F3_HU, 0, 0, 32'hBEEF_1234, st, be_s, addr_s, wdata_s);
    check("lhu_be", be_s, 4'b1100);
    check("lhu_load", load_data, 32'h0000_BEEF);
    check("lhu_stalls", st, 2);
    tick();

    // LW 0x401 (misaligned)
`ifdef DMEM_MISALIGN_TRAP_EN
    Dcache_en    = 1'b1;
    Dcache_write = 1'b0;
    D_address    = 32'h0000_0401;
    funct3_MEM   = F3_W;
    tick();
    Dcache_en    = 1'b0;
    #1;
    check("lwmis_req", bus.mem_req, 0);
    check("lwmis_pulse", mem_misalign, 1);
    check("lwmis_load", load_data, 32'h0000_BEEF);
    $display("txn load addr=00000401 trapped misalign=%b load_data=%h", mem_misalign, load_data);
    tick();
    check("lwmis_pulse_end", mem_misalign, 0);
    check("lwmis_req_after", bus.mem_req, 0);
`else
    access(1'b0, 32'h0000_0401, 32'h0, F3_W, 0, 1, 32'h1122_3344, st, be_s, addr_s, wdata_s);
    check("lwmis_addr", addr_s, 32'h0000_0400);
    check("lwmis_be", be_s, 4'b1111);
    check("lwmis_load", load_data, 32'h1122_3344);
    check("lwmis_flag", mem_misalign, 0);
    tick();
`endif

    // LW 0x500 with Istall across DONE; stray rvalid in IDLE ignored
    access(1'b0, 32'h0000_0500, 32'h0, F3_W, 1, 1, 32'hCAFE_F00D, st, be_s, addr_s, wdata_s);
    check("lw_load", load_data, 32'hCAFE_F00D);
    Istall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = (k == 1);
      bus.mem_rdata  = 32'h0;
      #1;
      check("istall_hold", load_data, 32'hCAFE_F00D);
      tick();
    end
    Istall         = 1'b0;
    bus.mem_rvalid = 1'b0;

    // Reset during WAIT_R, then a late rvalid
    Dcache_en       = 1'b1;
    Dcache_write    = 1'b0;
    D_address       = 32'h0000_0600;
    Read_data_2_MEM = 32'h5555_5555;
    funct3_MEM      = F3_W;
    tick();
    Dcache_en   = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    #1;
    check("midrst_wait_stall", Dstall, 1);
    rst = 1'b0;
    #1;
    check("midrst_req", bus.mem_req, 0);
    check("midrst_load", load_data, 0);
    check("midrst_stall", Dstall, 0);
    check("midrst_addr", bus.mem_addr, 0);
    check("midrst_be", bus.mem_be, 0);
    tick();
    rst            = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    #1;
    check("late_rvalid_load", load_data, 0);
    check("late_rvalid_stall", Dstall, 0);
    $display("txn reset-abandon load_data=%h Dstall=%b", load_data, Dstall);

    // FSM back in IDLE: a fresh LB on lane 0 works
    access(1'b0, 32'h0000_0000, 32'h0, F3_B, 0, 1, 32'hFFFF_FF7F, st, be_s, addr_s, wdata_s);
    check("lb0_be", be_s, 4'b0001);
    check("lb0_load", load_data, 32'h0000_007F);
    tick();

    // LH sign extension on upper half
    access(1'b0, 32'h0000_0702, 32'h0, F3_H, 0, 0, 32'h8001_7FFF, st, be_s, addr_s, wdata_s);
    check("lh_load", load_data, 32'hFFFF_8001);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock domain, reset asynchronous and active-low:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
Dcache_en  in  1  MEM-stage access request; high for exactly the first MEM cycle of an access
Dcache_write  in  1  1 = store, 0 = load; valid with Dcache_en
D_address  in  32  byte address; valid with Dcache_en
Read_data_2_MEM  in  32  store data; valid with Dcache_en
funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
Istall  in  1  fetch-side stall; the pipeline does not advance while high
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word-aligned address, bits [1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
Dstall  out  1  holds pipeline while access outstanding
load_data  out  32  extended load result
mem_misalign  out  1  one-cycle misaligned-access pulse

Function
REQ-002 The FSM SHALL have four states: IDLE, REQ, WAIT_R, DONE.
REQ-003 In IDLE with Dcache_en=1, the block SHALL latch D_address, Dcache_write, funct3_MEM and Read_data_2_MEM and go to REQ; Dstall SHALL be 1 combinationally in that same cycle.
REQ-004 Dstall SHALL be 1 in REQ and WAIT_R, and 0 in IDLE (except per REQ-003) and in DONE.
REQ-005 In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata SHALL be stable until the cycle mem_gnt=1.
REQ-006 On mem_gnt in REQ: a store SHALL go to DONE; a load SHALL go to WAIT_R, or straight to DONE when mem_rvalid=1 in the same cycle (mem_rdata captured).
REQ-007 In WAIT_R, mem_req SHALL be 0; on mem_rvalid the block SHALL capture the extended mem_rdata into load_data and go to DONE.
REQ-008 DONE SHALL last exactly one cycle and then go to IDLE; Dcache_en in DONE SHALL be ignored.
REQ-009 Byte enables SHALL be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W and any other funct3 4'b1111.
REQ-010 Store data SHALL be {4{rs2[7:0]}} for B, {2{rs2[15:0]}} for H, and rs2 for W.
REQ-011 Load extraction SHALL select the lane using latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W and unlisted funct3 pass the word through unchanged.
REQ-012 load_data SHALL hold its value until the next load completes, including across Istall and store accesses.
REQ-013 mem_gnt or mem_rvalid arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-014 With rst=0, the FSM SHALL go to IDLE and mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, mem_misalign and all latched fields SHALL be 0; Dstall SHALL be 0 unless REQ-003 applies.
REQ-015 Reset asserted mid-access SHALL abandon the access immediately; a late mem_rvalid after reset SHALL be ignored per REQ-013.

Configuration
REQ-016 With DMEM_MISALIGN_TRAP_EN defined, an H access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL skip REQ, issue no mem_req, go from IDLE directly to DONE, pulse mem_misalign for that DONE cycle, and leave load_data unchanged.
REQ-017 Without DMEM_MISALIGN_TRAP_EN, mem_misalign SHALL be tied to 0, and misaligned accesses SHALL proceed with the offending low address bits forced to 0 for byte-enable and lane selection.

Structure
REQ-018 Package dmem_pkg SHALL hold the state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-019 The combinational lane logic (be, wdata replication, load extract) SHALL be one sub-module, dmem_lane_align; the FSM and registers stay in dmem_access_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> mem_be=1111, mem_wdata=0xDEADBEEF, Dstall high 4 cycles (IDLE, REQ x3), then DONE.
- LB addr 0x203, rdata 0x80FFFFFF, rvalid 3 cycles after gnt -> load_data=0xFFFFFF80, mem_be=1000.
- LHU addr 0x302, gnt and rvalid same cycle, rdata 0xBEEF1234 -> load_data=0x0000BEEF, WAIT_R skipped.
- LW addr 0x401 -> with macro: no mem_req, mem_misalign one pulse, load_data unchanged; without macro: mem_addr=0x400, be=1111.
- Reset low while in WAIT_R, then rvalid -> mem_req=0, load_data=0, FSM IDLE, rvalid ignored.
- Istall=1 during DONE of LW -> load_data stable for all Istall cycles.
